event_arbiter: RTL and testbench
================================

# event_arbiter

Round-robin arbiter and sequencer sharing one event-filter datapath between `N_SRC` event sources (x, y, t, p tuples). Each source presents events on a valid/ready handshake. The block grants one source per cycle, registers the winning event with a source tag, and presents it downstream on a valid/ready output. An enable-driven state machine starts and cleanly drains the stream. A saturating counter records accepted events.

## Interface
- `N_SRC`, default 4: number of requesting sources (2..8)
- `XY_W`, default 2: width of x and y
- `T_W`, default 2: timestamp width
- `P_W`, default 2: polarity field width
- `CNT_W`, default 8: accepted-event counter width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  run enable
- `src_valid`  in  `N_SRC`  per-source event valid
- `src_ready`  out  `N_SRC`  per-source accept (one-hot or zero)
- `src_x`  in  `N_SRC*XY_W`  packed; source i at `[i*XY_W +: XY_W]`
- `src_y`  in  `N_SRC*XY_W`  packed as above
- `src_t`  in  `N_SRC*T_W`  packed
- `src_p`  in  `N_SRC*P_W`  packed
- `ev_valid`  out  1  output event valid
- `ev_ready`  in  1  downstream accept
- `ev_x`, `ev_y`  out  `XY_W`  registered event coordinates
- `ev_t`  out  `T_W`  registered timestamp
- `ev_p`  out  `P_W`  registered polarity
- `ev_src`  out  `$clog2(N_SRC)`  index of originating source
- `busy`  out  1  state != IDLE
- `ev_count`  out  `CNT_W`  accepted-event count, saturating

## Operation
- **States**
  - IDLE → RUN when `en`=1.
  - RUN → IDLE when `en`=0 and the output register is empty or being accepted this cycle.
  - RUN → DRAIN when `en`=0, `ev_valid`=1 and `ev_ready`=0.
  - DRAIN → IDLE on `ev_valid && ev_ready`. `en` is ignored in DRAIN.
- **Load condition:** `load = (state==RUN) && en && (!ev_valid || ev_ready)`.
- **Arbitration**
  - Rotating priority pointer `ptr`. Candidates are scanned from `ptr` upward, modulo `N_SRC`. The first source with `src_valid`=1 wins.
  - `src_ready[w]` = `load`. All other `src_ready` bits are 0.
  - `src_ready` is combinational from `src_valid`, state, `en`, `ev_valid` and `ev_ready`.
  - On a transfer, `ptr` ← (w+1) mod `N_SRC`. With no transfer, `ptr` holds.
- **Output register**
  - On a transfer, capture the winner's x, y, t, p, set `ev_src` = w, and set `ev_valid` = 1.
  - On `ev_valid && ev_ready` with no new load, clear `ev_valid`.
  - While `ev_valid && !ev_ready`, all `ev_*` outputs are held stable.
- **Counter:** `ev_count` increments on each source transfer and saturates at all-ones.
- **Reset values:** `ev_valid`=0, `ev_x/y/t/p/src`=0, `ptr`=0, `ev_count`=0, state IDLE, `busy`=0, `src_ready`=0.
- **Reset mid-operation:** any held event is discarded and `ev_valid` drops asynchronously.

## Timing
- Latency is 1 cycle: a source transfer at edge k gives `ev_valid`=1 after edge k.
- Throughput is 1 event per cycle while `ev_ready`=1. There are no bubbles when sources remain valid.
- `ev_valid`, once asserted, stays high until accepted. Output data never changes while `ev_valid && !ev_ready`.
- Simultaneous accept and load in one cycle: the register is overwritten with the new event and `ev_valid` stays 1.
- After `en` falls, no new `src_ready` is asserted from that same cycle onward.
- Fairness: a continuously valid source is granted within `N_SRC` transfers.
- Counter saturation: at all-ones, further transfers leave `ev_count` unchanged. Transfers themselves proceed normally.

## Structure
- **Package `event_pkg`**
  - default widths for x/y/t/p
  - `state_t` enum with values IDLE, RUN and DRAIN
  - `event_t` struct `{x, y, t, p}`
- **Sub-module `rr_arbiter`** (parameter `N`)
  - inputs: `req`, `ptr`
  - outputs: one-hot `gnt`, index `gnt_idx`, `any`
  - purely combinational. `ptr` update and the FSM stay in `event_arbiter`.

## Test plan
- **Single source:** en=1, src0 valid with x=2, y=1, t=3, p=1, ev_ready=1 → src_ready[0] same cycle; next cycle ev_valid=1, ev_x=2, ev_y=1, ev_t=3, ev_p=1, ev_src=0; ev_count=1.
- **Round-robin:** all 4 sources valid continuously, ev_ready=1 → ev_src sequence 0,1,2,3,0,…; one event per cycle.
- **Backpressure:** ev_ready=0 for 5 cycles with src1 valid → exactly one transfer; outputs stable for 5 cycles, src_ready=0; on ev_ready=1, a second event follows back-to-back.
- **Drain:** event held with ev_ready=0, then en→0 → state DRAIN, busy=1, src_ready=0; ev_ready=1 → ev_valid=0 and busy=0 the next cycle.
- **Counter saturation:** CNT_W=2, 5 transfers → ev_count reads 1,2,3,3,3.
- **Async reset mid-stream:** rst_n=0 between edges while ev_valid=1 → ev_valid=0, ev_count=0 and busy=0 immediately; after release, the first grant goes to src0.

Source files
------------

// File: rtl/event_pkg.sv
// Shared types and default widths for the event arbiter.
//   state_t : sequencer states (IDLE, RUN, DRAIN)
//   event_t : one event payload at the default widths
package event_pkg;

  localparam int unsigned N_SRC_DEF = 4;
  localparam int unsigned XY_W_DEF  = 2;
  localparam int unsigned T_W_DEF   = 2;
  localparam int unsigned P_W_DEF   = 2;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [XY_W_DEF-1:0] x;
    logic [XY_W_DEF-1:0] y;
    logic [T_W_DEF-1:0]  t;
    logic [P_W_DEF-1:0]  p;
  } event_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted request
//   any     : at least one request present
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int unsigned IDX_W = $clog2(N);

  // Scan from ptr upward, wrapping at N; first requester wins.
  always_comb begin : scan
    logic [IDX_W-1:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/event_arbiter.sv
// Round-robin arbiter/sequencer feeding one registered event output.
//   en                  : run enable; falling en drains the held event
//   src_valid/src_ready : per-source handshake (ready is combinational)
//   src_x/y/t/p         : packed per-source event fields
//   ev_valid/ev_ready   : downstream handshake
//   ev_x/y/t/p, ev_src  : registered event and its source index
//   busy                : sequencer not idle
//   ev_count            : saturating count of accepted source events
module event_arbiter
  import event_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned XY_W  = XY_W_DEF,
  parameter int unsigned T_W   = T_W_DEF,
  parameter int unsigned P_W   = P_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [N_SRC-1:0]          src_valid,
  output logic [N_SRC-1:0]          src_ready,
  input  logic [N_SRC*XY_W-1:0]     src_x,
  input  logic [N_SRC*XY_W-1:0]     src_y,
  input  logic [N_SRC*T_W-1:0]      src_t,
  input  logic [N_SRC*P_W-1:0]      src_p,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [XY_W-1:0]           ev_x,
  output logic [XY_W-1:0]           ev_y,
  output logic [T_W-1:0]            ev_t,
  output logic [P_W-1:0]            ev_p,
  output logic [$clog2(N_SRC)-1:0]  ev_src,
  output logic                      busy,
  output logic [CNT_W-1:0]          ev_count
);

  localparam int unsigned IDX_W = $clog2(N_SRC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

  state_t           state_q, state_d;
  logic             load;
  logic             xfer;
  logic [N_SRC-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_nxt;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .req     (src_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and load qualification; loads only while running and enabled.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN: begin
        load = en && (!ev_valid || ev_ready);
        if (!en) state_d = (ev_valid && !ev_ready) ? DRAIN : IDLE;
      end
      DRAIN: if (ev_valid && ev_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign xfer      = load && gnt_any;
  assign src_ready = load ? gnt : '0;
  assign busy      = (state_q != IDLE);
  assign ptr_nxt   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);

  // Output register, priority pointer and accepted-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_x     <= '0;
      ev_y     <= '0;
      ev_t     <= '0;
      ev_p     <= '0;
      ev_src   <= '0;
      ptr_q    <= '0;
      ev_count <= '0;
    end else begin
      if (xfer) begin
        ev_valid <= 1'b1;
        ev_x     <= src_x[int'(gnt_idx)*XY_W +: XY_W];
        ev_y     <= src_y[int'(gnt_idx)*XY_W +: XY_W];
        ev_t     <= src_t[int'(gnt_idx)*T_W +: T_W];
        ev_p     <= src_p[int'(gnt_idx)*P_W +: P_W];
        ev_src   <= gnt_idx;
        ptr_q    <= ptr_nxt;
        if (ev_count != '1) ev_count <= ev_count + CNT_W'(1);
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_event_arbiter.sv
// Self-checking bench for event_arbiter with a scoreboard of expected events.
module tb_event_arbiter;
  import event_pkg::*;

  localparam int N     = 4;
  localparam int XY_W  = 2;
  localparam int T_W   = 2;
  localparam int P_W   = 2;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] t;
    logic [1:0] p;
    logic [1:0] src;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [N-1:0]       src_valid;
  logic [N-1:0]       src_ready;
  logic [N*XY_W-1:0]  src_x, src_y;
  logic [N*T_W-1:0]   src_t;
  logic [N*P_W-1:0]   src_p;
  logic               ev_valid, ev_ready;
  logic [XY_W-1:0]    ev_x, ev_y;
  logic [T_W-1:0]     ev_t;
  logic [P_W-1:0]     ev_p;
  logic [1:0]         ev_src;
  logic               busy;
  logic [CNT_W-1:0]   ev_count;

  int     errors = 0;
  int     checks = 0;
  exp_t   q[$];
  int     m_ptr;
  state_t m_state;
  bit     m_valid;
  int     m_cnt;

  event_arbiter #(.N_SRC(N), .XY_W(XY_W), .T_W(T_W), .P_W(P_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_x(src_x), .src_y(src_y), .src_t(src_t), .src_p(src_p),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x(ev_x), .ev_y(ev_y), .ev_t(ev_t), .ev_p(ev_p), .ev_src(ev_src),
    .busy(busy), .ev_count(ev_count)
  );

  always #5 clk = ~clk;

  task automatic set_src(input int i, input logic [1:0] x, input logic [1:0] y,
                         input logic [1:0] t, input logic [1:0] p);
    src_x[i*XY_W +: XY_W] = x;
    src_y[i*XY_W +: XY_W] = y;
    src_t[i*T_W +: T_W]   = t;
    src_p[i*P_W +: P_W]   = p;
  endtask

  task automatic rand_src(input int i);
    set_src(i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_state = IDLE;
    m_valid = 1'b0;
    m_cnt   = 0;
    q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    src_valid = '0;
    ev_ready  = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus already driven: check handshake, scoreboard, then advance.
  task automatic cycle();
    int         w;
    bit         mload;
    bit         old_valid;
    logic [1:0] idx;
    logic [N-1:0] exp_rdy;
    exp_t       e;
    #1;
    old_valid = m_valid;
    mload = (m_state == RUN) && en && (!m_valid || ev_ready);
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = 2'((m_ptr + k) % N);
      if (w < 0 && src_valid[idx]) w = int'(idx);
    end
    exp_rdy = '0;
    if (mload && w >= 0) exp_rdy[w] = 1'b1;
    checks++;
    if (src_ready !== exp_rdy) begin
      errors++;
      $display("FAIL src_ready: got %b want %b at %0t", src_ready, exp_rdy, $time);
    end
    checks++;
    if (ev_valid !== m_valid) begin
      errors++;
      $display("FAIL ev_valid: got %b want %b at %0t", ev_valid, m_valid, $time);
    end
    if (m_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got none want one expected event at %0t", $time);
      end else begin
        if ({ev_x, ev_y, ev_t, ev_p, ev_src} !== q[0]) begin
          errors++;
          $display("FAIL ev_data: got %h want %h at %0t",
                   {ev_x, ev_y, ev_t, ev_p, ev_src}, q[0], $time);
        end
        if (ev_ready) void'(q.pop_front());
      end
    end
    if (mload && w >= 0) begin
      e.x   = src_x[w*XY_W +: XY_W];
      e.y   = src_y[w*XY_W +: XY_W];
      e.t   = src_t[w*T_W +: T_W];
      e.p   = src_p[w*P_W +: P_W];
      e.src = 2'(w);
      q.push_back(e);
      m_ptr   = (w + 1) % N;
      m_valid = 1'b1;
      if (m_cnt < MAXC) m_cnt++;
    end else if (m_valid && ev_ready) begin
      m_valid = 1'b0;
    end
    case (m_state)
      IDLE:    if (en) m_state = RUN;
      RUN:     if (!en) m_state = (old_valid && !ev_ready) ? DRAIN : IDLE;
      DRAIN:   if (old_valid && ev_ready) m_state = IDLE;
      default: m_state = IDLE;
    endcase
    @(posedge clk);
    #1;
    checks++;
    if (ev_count !== CNT_W'(m_cnt)) begin
      errors++;
      $display("FAIL ev_count: got %0d want %0d at %0t", ev_count, m_cnt, $time);
    end
    checks++;
    if (busy !== (m_state != IDLE)) begin
      errors++;
      $display("FAIL busy: got %b want %b at %0t", busy, (m_state != IDLE), $time);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ev_valid, busy, src_ready, ev_count, ev_x, ev_y, ev_t, ev_p, ev_src} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0",
               {ev_valid, busy, src_ready, ev_count, ev_x, ev_y, ev_t, ev_p, ev_src});
    end
  endtask

  task automatic test_single();
    do_reset();
    set_src(0, 2'd2, 2'd1, 2'd3, 2'd1);
    src_valid = 4'b0001;
    en        = 1'b1;
    ev_ready  = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({ev_valid, ev_x, ev_y, ev_t, ev_p, ev_src, ev_count} !== {1'b1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd1}) begin
      errors++;
      $display("FAIL single_event: got %h want %h",
               {ev_valid, ev_x, ev_y, ev_t, ev_p, ev_src, ev_count},
               {1'b1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd1});
    end
    src_valid = '0;
    cycle();
  endtask

  task automatic test_round_robin();
    int exp_src = 0;
    do_reset();
    src_valid = 4'hf;
    en        = 1'b1;
    ev_ready  = 1'b1;
    for (int c = 0; c < 13; c++) begin
      for (int i = 0; i < N; i++) rand_src(i);
      cycle();
      if (c >= 1) begin
        checks++;
        if (ev_valid !== 1'b1 || ev_src !== 2'(exp_src)) begin
          errors++;
          $display("FAIL rr_order: got valid=%b src=%0d want valid=1 src=%0d", ev_valid, ev_src, exp_src);
        end
        exp_src = (exp_src + 1) % N;
      end
    end
    src_valid = '0;
    cycle();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_src(1, 2'd3, 2'd2, 2'd1, 2'd0);
    src_valid = 4'b0010;
    en        = 1'b1;
    ev_ready  = 1'b0;
    cycle();
    cycle();
    for (int c = 0; c < 5; c++) cycle();
    checks++;
    if (ev_count !== 2'd1) begin
      errors++;
      $display("FAIL bp_single_xfer: got %0d want 1", ev_count);
    end
    set_src(1, 2'd1, 2'd3, 2'd2, 2'd3);
    ev_ready = 1'b1;
    cycle();
    checks++;
    if ({ev_valid, ev_x, ev_y, ev_t, ev_p, ev_src, ev_count} !== {1'b1, 2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2}) begin
      errors++;
      $display("FAIL bp_back_to_back: got %h want %h",
               {ev_valid, ev_x, ev_y, ev_t, ev_p, ev_src, ev_count},
               {1'b1, 2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2});
    end
    src_valid = '0;
    cycle();
  endtask

  task automatic test_drain();
    do_reset();
    rand_src(2);
    src_valid = 4'b0100;
    en        = 1'b1;
    ev_ready  = 1'b0;
    cycle();
    cycle();
    en = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b1 || ev_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_enter: got busy=%b valid=%b want busy=1 valid=1", busy, ev_valid);
    end
    en = 1'b1;
    cycle();
    en       = 1'b0;
    ev_ready = 1'b1;
    cycle();
    checks++;
    if (busy !== 1'b0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: got busy=%b valid=%b want busy=0 valid=0", busy, ev_valid);
    end
    src_valid = '0;
    cycle();
  endtask

  task automatic test_saturation();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    do_reset();
    src_valid = 4'b0001;
    en        = 1'b1;
    ev_ready  = 1'b1;
    rand_src(0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      rand_src(0);
      cycle();
      checks++;
      if (ev_count !== 2'(exp_cnt[k]) || ev_valid !== 1'b1) begin
        errors++;
        $display("FAIL sat_count[%0d]: got cnt=%0d valid=%b want cnt=%0d valid=1", k, ev_count, ev_valid, exp_cnt[k]);
      end
    end
    src_valid = '0;
    cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < N; i++) rand_src(i);
    src_valid = 4'hf;
    en        = 1'b1;
    ev_ready  = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n     = 1'b0;
    en        = 1'b0;
    src_valid = '0;
    #1;
    checks++;
    if ({ev_valid, ev_count, busy, src_ready} !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b cnt=%0d busy=%b rdy=%b want all 0",
               ev_valid, ev_count, busy, src_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    src_valid = 4'hf;
    en        = 1'b1;
    ev_ready  = 1'b1;
    cycle();
    cycle();
    checks++;
    if (ev_valid !== 1'b1 || ev_src !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_grant: got valid=%b src=%0d want valid=1 src=0", ev_valid, ev_src);
    end
    src_valid = '0;
    cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    src_valid = '0;
    ev_ready  = 1'b0;
    src_x     = '0;
    src_y     = '0;
    src_t     = '0;
    src_p     = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
